// File: rtl/sseg_scan.sv
// sseg_scan: four-slot seven-segment scanner for a gear indicator.
// A prescaler divides clk down to one slot period.
// A 2-bit digit index walks slots 0..3.
// Each slot lights its character (R, N, D) only when the active gear matches it.
// Slot 3 is always blank because the downstream stage owns that position.
// Gear requests are buffered in a pending register.
// They are promoted to the active gear only at the frame wrap, so a frame is never torn.
module sseg_scan #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gear_in,
    input  logic       gear_valid,
    output logic [3:0] an_sel,
    output logic [6:0] char_sel,
    output logic       frame_tick
);

    localparam int unsigned     CW   = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   LAST = CW'(REFRESH_DIV - 1);

    localparam logic [1:0] GEAR_D = 2'b01;
    localparam logic [1:0] GEAR_N = 2'b10;
    localparam logic [1:0] GEAR_R = 2'b11;

    localparam logic [6:0] PAT_R     = 7'b0101111;
    localparam logic [6:0] PAT_N     = 7'b0101011;
    localparam logic [6:0] PAT_D     = 7'b0100001;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    logic [CW-1:0] presc;
    logic          tick;
    logic          wrap;
    logic [1:0]    idx;
    logic          upd;
    logic [1:0]    pending;
    logic [1:0]    active;
    logic [3:0]    an_next;
    logic [6:0]    char_next;

    assign tick = (presc == LAST);
    assign wrap = tick && (idx == 2'd3);

    // Prescaler: free-running 0..REFRESH_DIV-1, independent of gear traffic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Digit index: advance one slot per tick, modulo 4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= 2'd0;
        end else if (tick) begin
            idx <= idx + 2'd1;
        end
    end

    // Gear buffering: the latest strobe goes to pending.
    // Active loads only at the wrap; a strobe in the wrap cycle bypasses pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 2'b00;
            active  <= 2'b00;
        end else begin
            if (gear_valid) begin
                pending <= gear_in;
            end
            if (wrap) begin
                active <= gear_valid ? gear_in : pending;
            end
        end
    end

    // Update strobe: outputs refresh the cycle after the index moves.
    // frame_tick rises together with the first idx0 display of a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd        <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            upd        <= tick;
            frame_tick <= upd && (idx == 2'd0);
        end
    end

    // Slot decode: anode and character for the current index and active gear.
    always_comb begin
        an_next   = 4'b1111;
        char_next = PAT_BLANK;
        case (idx)
            2'd0: begin
                an_next   = 4'b1110;
                char_next = (active == GEAR_R) ? PAT_R : PAT_BLANK;
            end
            2'd1: begin
                an_next   = 4'b1101;
                char_next = (active == GEAR_N) ? PAT_N : PAT_BLANK;
            end
            2'd2: begin
                an_next   = 4'b1011;
                char_next = (active == GEAR_D) ? PAT_D : PAT_BLANK;
            end
            default: begin
                an_next   = 4'b0111;
                char_next = PAT_BLANK;
            end
        endcase
    end

    // Output register: anode and character load together.
    // This keeps the digit and its character from ever being mixed across slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_sel   <= 4'b1111;
            char_sel <= PAT_BLANK;
        end else if (upd) begin
            an_sel   <= an_next;
            char_sel <= char_next;
        end
    end

endmodule

// File: tb/tb_sseg_scan.sv
// Bench for sseg_scan with a four-cycle slot period.
// Expected values come from a cycle-count model of the scan schedule and the gear handoff rules.
module tb_sseg_scan;

    localparam int unsigned DIV = 4;

    localparam logic [6:0] P_R     = 7'b0101111;
    localparam logic [6:0] P_N     = 7'b0101011;
    localparam logic [6:0] P_D     = 7'b0100001;
    localparam logic [6:0] P_BLANK = 7'b1111111;

    logic       clk;
    logic       rst;
    logic [1:0] gear_in;
    logic       gear_valid;
    logic [3:0] an_sel;
    logic [6:0] char_sel;
    logic       frame_tick;

    int n_checks;
    int n_fail;

    // Model state.
    int unsigned cyc;
    int unsigned m_idx;
    logic [1:0]  m_active;
    logic [1:0]  m_pending;
    logic        m_started;
    logic        m_wrapped;
    logic [3:0]  exp_an;
    logic [6:0]  exp_char;
    logic        exp_ft;

    sseg_scan #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .gear_in    (gear_in),
        .gear_valid (gear_valid),
        .an_sel     (an_sel),
        .char_sel   (char_sel),
        .frame_tick (frame_tick)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] an_of(input int unsigned i);
        logic [3:0] one;
        one = 4'b0001;
        return 4'b1111 ^ (one << i);
    endfunction

    function automatic logic [6:0] char_of(input int unsigned i, input logic [1:0] g);
        if (i == 0 && g == 2'b11) return P_R;
        if (i == 1 && g == 2'b10) return P_N;
        if (i == 2 && g == 2'b01) return P_D;
        return P_BLANK;
    endfunction

    task automatic model_reset();
        cyc       = 0;
        m_idx     = 0;
        m_active  = 2'b00;
        m_pending = 2'b00;
        m_started = 1'b0;
        m_wrapped = 1'b0;
        exp_an    = 4'b1111;
        exp_char  = P_BLANK;
        exp_ft    = 1'b0;
    endtask

    // Driver: apply one cycle of input, advance the model, and return 1 time unit after the edge.
    task automatic step(input logic v, input logic [1:0] g);
        logic tk;
        logic wr;
        gear_valid = v;
        gear_in    = g;
        @(posedge clk);
        cyc = cyc + 1;
        // Outputs after this edge reflect the slot and gear that held before it.
        if (m_started) begin
            exp_an   = an_of(m_idx);
            exp_char = char_of(m_idx, m_active);
        end
        exp_ft = m_wrapped;
        tk = (cyc % DIV == 0);
        wr = tk && ((cyc / DIV) % 4 == 0);
        if (tk) begin
            m_idx     = (cyc / DIV) % 4;
            m_started = 1'b1;
        end
        if (wr) m_active = v ? g : m_pending;
        if (v) m_pending = g;
        m_wrapped = wr;
        #1;
        gear_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        gear_valid = 1'b0;
        gear_in = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({an_sel, char_sel, frame_tick} !== {4'b1111, P_BLANK, 1'b0}) begin
            n_fail++;
            $display("FAIL reset got an=%b char=%b ft=%b want an=1111 char=1111111 ft=0",
                     an_sel, char_sel, frame_tick);
        end
        #1 rst = 1'b1;
    endtask

    task automatic test_idle_scan();
        int ft_count;
        ft_count = 0;
        for (int i = 0; i < 48; i++) begin
            step(1'b0, 2'b00);
            if (frame_tick === 1'b1) ft_count++;
            n_checks++;
            if ({an_sel, char_sel, frame_tick} !== {exp_an, exp_char, exp_ft}) begin
                n_fail++;
                $display("FAIL idle_scan cyc=%0d got an=%b char=%b ft=%b want an=%b char=%b ft=%b",
                         cyc, an_sel, char_sel, frame_tick, exp_an, exp_char, exp_ft);
            end
        end
        // Cycles 1..48 contain frame pulses at cycles 17, 33.
        n_checks++;
        if (ft_count !== 2) begin
            n_fail++;
            $display("FAIL idle_frame_count got %0d want 2", ft_count);
        end
    endtask

    task automatic test_gear_d();
        // Reach the middle of a frame, then strobe D once.
        for (int i = 0; i < 6; i++) step(1'b0, 2'b00);
        step(1'b1, 2'b01);
        for (int i = 0; i < 48; i++) begin
            step(1'b0, 2'b00);
            n_checks++;
            if ({an_sel, char_sel, frame_tick} !== {exp_an, exp_char, exp_ft}) begin
                n_fail++;
                $display("FAIL gear_d cyc=%0d got an=%b char=%b ft=%b want an=%b char=%b ft=%b",
                         cyc, an_sel, char_sel, frame_tick, exp_an, exp_char, exp_ft);
            end
            if (char_sel === P_D) begin
                n_checks++;
                if (an_sel !== 4'b1011) begin
                    n_fail++;
                    $display("FAIL gear_d_slot got an=%b want 1011", an_sel);
                end
            end
        end
    endtask

    task automatic test_override();
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00);
        step(1'b1, 2'b10);
        step(1'b0, 2'b00);
        step(1'b1, 2'b11);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 2'b00);
            n_checks++;
            if ({an_sel, char_sel, frame_tick} !== {exp_an, exp_char, exp_ft}) begin
                n_fail++;
                $display("FAIL override cyc=%0d got an=%b char=%b ft=%b want an=%b char=%b ft=%b",
                         cyc, an_sel, char_sel, frame_tick, exp_an, exp_char, exp_ft);
            end
            n_checks++;
            if (char_sel === P_N) begin
                n_fail++;
                $display("FAIL override_no_n got char=%b want not 0101011", char_sel);
            end
        end
    endtask

    task automatic test_wrap_strobe();
        int budget;
        budget = 0;
        // The wrap tick lands on edges whose count is a multiple of 16.
        while (((cyc + 1) % (4 * DIV)) != 0 && budget < 40) begin
            step(1'b0, 2'b00);
            budget++;
        end
        n_checks++;
        if (budget >= 40) begin
            n_fail++;
            $display("FAIL wrap_align got budget=%0d want <40", budget);
        end
        step(1'b1, 2'b10);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 2'b00);
            n_checks++;
            if ({an_sel, char_sel, frame_tick} !== {exp_an, exp_char, exp_ft}) begin
                n_fail++;
                $display("FAIL wrap_strobe cyc=%0d got an=%b char=%b ft=%b want an=%b char=%b ft=%b",
                         cyc, an_sel, char_sel, frame_tick, exp_an, exp_char, exp_ft);
            end
            if (an_sel === 4'b1101) begin
                n_checks++;
                if (char_sel !== P_N) begin
                    n_fail++;
                    $display("FAIL wrap_strobe_n got char=%b want 0101011", char_sel);
                end
            end
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [1:0] g;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 7) == 0);
            g = 2'($urandom_range(0, 3));
            step(v, g);
            n_checks++;
            if ({an_sel, char_sel, frame_tick} !== {exp_an, exp_char, exp_ft}) begin
                n_fail++;
                $display("FAIL random cyc=%0d got an=%b char=%b ft=%b want an=%b char=%b ft=%b",
                         cyc, an_sel, char_sel, frame_tick, exp_an, exp_char, exp_ft);
            end
        end
    endtask

    task automatic test_async_reset();
        int budget;
        step(1'b1, 2'b01);
        budget = 0;
        while (!(exp_an == 4'b1011 && exp_char == P_D) && budget < 60) begin
            step(1'b0, 2'b00);
            budget++;
        end
        n_checks++;
        if (budget >= 60 || an_sel !== 4'b1011 || char_sel !== P_D) begin
            n_fail++;
            $display("FAIL async_setup got an=%b char=%b budget=%0d want an=1011 char=0100001",
                     an_sel, char_sel, budget);
        end
        // Strobe a new gear so the discarded pending value would show if it survived.
        step(1'b1, 2'b11);
        // Assert reset between edges and observe before the next edge.
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({an_sel, char_sel, frame_tick} !== {4'b1111, P_BLANK, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset got an=%b char=%b ft=%b want an=1111 char=1111111 ft=0",
                     an_sel, char_sel, frame_tick);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 2'b00);
            n_checks++;
            if ({an_sel, char_sel, frame_tick} !== {exp_an, exp_char, exp_ft}) begin
                n_fail++;
                $display("FAIL post_reset cyc=%0d got an=%b char=%b ft=%b want an=%b char=%b ft=%b",
                         cyc, an_sel, char_sel, frame_tick, exp_an, exp_char, exp_ft);
            end
            n_checks++;
            if (char_sel !== P_BLANK) begin
                n_fail++;
                $display("FAIL post_reset_blank got char=%b want 1111111", char_sel);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_idle_scan();
        test_gear_d();
        test_override();
        test_wrap_strobe();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
